// File: rtl/snd_mix4.sv
// Four-channel signed audio mixer: per-channel 4.4 gain, two-stage clock-enabled
// pipeline (multiply, then sum / floor-shift / saturate).
module snd_mix4 #(
   parameter int unsigned w0   = 16,
   parameter int unsigned w1   = 16,
   parameter int unsigned w2   = 16,
   parameter int unsigned w3   = 16,
   parameter int unsigned wout = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   input  logic signed [w0-1:0]   ch0,
   input  logic signed [w1-1:0]   ch1,
   input  logic signed [w2-1:0]   ch2,
   input  logic signed [w3-1:0]   ch3,
   input  logic        [7:0]      gain0,
   input  logic        [7:0]      gain1,
   input  logic        [7:0]      gain2,
   input  logic        [7:0]      gain3,
   output logic signed [wout-1:0] mixed
);

   localparam int unsigned PW = wout + 9;
   localparam int unsigned SW = wout + 11;

   localparam logic signed [wout-1:0] OUT_MAX = {1'b0, {(wout-1){1'b1}}};
   localparam logic signed [wout-1:0] OUT_MIN = {1'b1, {(wout-1){1'b0}}};

   generate
      if (w0 > wout || w1 > wout || w2 > wout || w3 > wout) begin : g_width_chk
         $error("snd_mix4: every channel width must be <= wout");
      end
   endgenerate

   logic signed [wout-1:0] ch_x   [4];
   logic signed [PW-1:0]   gain_x [4];
   logic signed [PW-1:0]   prod   [4];
   logic signed [PW-1:0]   p_q    [4];
   logic signed [SW-1:0]   sum;
   logic signed [SW-1:0]   shr;
   logic signed [wout-1:0] sat;

   // Channels are integers: sign-extend only, gains become non-negative signed operands.
   always_comb begin
      ch_x[0]   = wout'(ch0);
      ch_x[1]   = wout'(ch1);
      ch_x[2]   = wout'(ch2);
      ch_x[3]   = wout'(ch3);
      gain_x[0] = PW'($signed({1'b0, gain0}));
      gain_x[1] = PW'($signed({1'b0, gain1}));
      gain_x[2] = PW'($signed({1'b0, gain2}));
      gain_x[3] = PW'($signed({1'b0, gain3}));
      for (int i = 0; i < 4; i++) begin
         prod[i] = PW'(ch_x[i]) * gain_x[i];
      end
   end

   // Stage 1: register raw products; the 4.4 scaling is applied after the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) p_q[i] <= '0;
      end else if (cen) begin
         for (int i = 0; i < 4; i++) p_q[i] <= prod[i];
      end
   end

   // Sum is wide enough that it cannot overflow; >>> floors toward minus infinity.
   always_comb begin
      sum = SW'(p_q[0]) + SW'(p_q[1]) + SW'(p_q[2]) + SW'(p_q[3]);
      shr = sum >>> 4;
      sat = shr[wout-1:0];
      if (shr > SW'(OUT_MAX)) begin
         sat = OUT_MAX;
      end else if (shr < SW'(OUT_MIN)) begin
         sat = OUT_MIN;
      end
   end

   // Stage 2: saturated output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mixed <= '0;
      end else if (cen) begin
         mixed <= sat;
      end
   end

endmodule

// File: tb/tb_snd_mix4.sv
// Randomized and directed bench for snd_mix4 against an arithmetic reference model
// that tracks the two-cen-pulse latency.
module tb_snd_mix4;

   logic               clk;
   logic               rst_n;
   logic               cen;
   logic signed [15:0] ch0, ch1, ch3;
   logic signed [13:0] ch2;
   logic        [7:0]  gain0, gain1, gain2, gain3;
   logic signed [15:0] mixed;

   int n_cmp;
   int n_bad;

   longint exp_pipe;
   longint exp_out;

   snd_mix4 #(.w0(16), .w1(16), .w2(14), .w3(16), .wout(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .ch0   (ch0),
      .ch1   (ch1),
      .ch2   (ch2),
      .ch3   (ch3),
      .gain0 (gain0),
      .gain1 (gain1),
      .gain2 (gain2),
      .gain3 (gain3),
      .mixed (mixed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Mix of one input sample: gains are value/16, result floored then clipped.
   function automatic longint ref_mix();
      longint s;
      s = longint'(ch0) * longint'(gain0) + longint'(ch1) * longint'(gain1)
        + longint'(ch2) * longint'(gain2) + longint'(ch3) * longint'(gain3);
      s = s >>> 4;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   // One clock: advance the model on cen edges, then check the output.
   task automatic tick(input string tag);
      @(posedge clk);
      if (cen && rst_n) begin
         exp_out  = exp_pipe;
         exp_pipe = ref_mix();
      end
      #1;
      chk(tag, longint'(mixed), exp_out);
   endtask

   task automatic apply(input logic signed [15:0] c0, input logic [7:0] g0,
                        input logic signed [15:0] c1, input logic [7:0] g1,
                        input logic signed [13:0] c2, input logic [7:0] g2,
                        input logic signed [15:0] c3, input logic [7:0] g3);
      ch0 = c0; gain0 = g0;
      ch1 = c1; gain1 = g1;
      ch2 = c2; gain2 = g2;
      ch3 = c3; gain3 = g3;
   endtask

   // Apply a vector with cen every cycle, wait two pulses, check against a constant.
   task automatic directed(input string tag,
                           input logic signed [15:0] c0, input logic [7:0] g0,
                           input logic signed [15:0] c1, input logic [7:0] g1,
                           input logic signed [13:0] c2, input logic [7:0] g2,
                           input longint want);
      apply(c0, g0, c1, g1, c2, g2, 16'sd0, 8'h00);
      cen = 1'b1;
      tick({tag, "_p1"});
      tick({tag, "_p2"});
      chk(tag, longint'(mixed), want);
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      exp_pipe = 0;
      exp_out  = 0;
      rst_n    = 1'b0;
      cen      = 1'b0;
      apply(16'sd0, 8'h00, 16'sd0, 8'h00, 14'sd0, 8'h00, 16'sd0, 8'h00);

      #22;
      chk("reset_state", longint'(mixed), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      directed("unity_pos",   16'sd1000,  8'h10, 16'sd0, 8'h00, 14'sd0, 8'h00, 1000);
      directed("unity_neg",  -16'sd1000,  8'h10, 16'sd0, 8'h00, 14'sd0, 8'h00, -1000);
      directed("gain_sum",    16'sh1000,  8'h40, 16'sd0, 8'h00, 14'sh0100, 8'h10, 64'h4100);
      directed("sat_pos",     16'sh4000,  8'h40, 16'sd0, 8'h00, 14'sd0, 8'h00, 32767);
      directed("sat_neg",    -16'sh4000,  8'h40, 16'sd0, 8'h00, 14'sd0, 8'h00, -32768);
      directed("sat_two",     16'sh7FFF,  8'h10, 16'sh7FFF, 8'h10, 14'sd0, 8'h00, 32767);
      directed("floor_m1",   -16'sd1,     8'h01, 16'sd0, 8'h00, 14'sd0, 8'h00, -1);
      directed("floor_15",    16'sd15,    8'h01, 16'sd0, 8'h00, 14'sd0, 8'h00, 0);
      directed("floor_16",    16'sd16,    8'h01, 16'sd0, 8'h00, 14'sd0, 8'h00, 1);
      directed("gain_zero",   16'sh7FFF,  8'h00, 16'sd100, 8'h10, 14'sd0, 8'h00, 100);
      directed("gain_max",    16'sd16,    8'hFF, 16'sd0, 8'h00, 14'sd0, 8'h00, 255);
      directed("ch2_negext",  16'sd0,     8'h00, 16'sd0, 8'h00, -14'sd8192, 8'h10, -8192);

      // Sparse cen: input changes between pulses must not reach the output early.
      for (int c = 0; c < 96; c++) begin
         cen = (c % 8 == 0);
         ch0 = 16'($urandom);
         gain0 = 8'($urandom_range(0, 32));
         tick("cen_gate");
      end

      // Mid-stream asynchronous reset.
      apply(16'sh1234, 8'h10, 16'sd0, 8'h00, 14'sd0, 8'h00, 16'sd0, 8'h00);
      cen = 1'b1;
      tick("pre_rst_p1");
      tick("pre_rst_p2");
      chk("pre_rst_val", longint'(mixed), 64'h1234);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async", longint'(mixed), 0);
      exp_pipe = 0;
      exp_out  = 0;
      cen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) tick("rst_hold");
      cen = 1'b1;
      tick("rst_p1");
      tick("rst_p2");
      chk("rst_recover", longint'(mixed), 64'h1234);

      // Random mixing with random cen.
      for (int c = 0; c < 400; c++) begin
         cen = ($urandom_range(0, 9) < 7);
         ch0 = 16'($urandom);
         ch1 = 16'($urandom);
         ch2 = 14'($urandom);
         ch3 = 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            gain0 = 8'($urandom); gain1 = 8'($urandom);
            gain2 = 8'($urandom); gain3 = 8'($urandom);
         end else begin
            gain0 = 8'($urandom_range(0, 8)); gain1 = 8'($urandom_range(0, 8));
            gain2 = 8'($urandom_range(0, 8)); gain3 = 8'($urandom_range(0, 8));
         end
         tick("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
